// File: rtl/pc_unit_pkg.sv
// Shared definitions for the program-counter unit: trap cause codes,
// sequencer states and the default trap vector.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXT      = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    localparam logic [31:0] DEF_EXC_VEC = 32'h0000_00FC;

endpackage

// File: rtl/pc_src_mux.sv
// N-way PC source selector. Index 0 is the internal EPC and indices
// 1..NSRC-1 are unpacked from the flat source bus. Any select at or above
// NSRC falls back to the last source, matching the old default arm.
module pc_src_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 5,
    parameter int SEL_W = $clog2(NSRC)
) (
    input  logic [WIDTH-1:0]            epc_i,
    input  logic [(NSRC-1)*WIDTH-1:0]   src_flat_i,
    input  logic [SEL_W-1:0]            sel_i,
    output logic [WIDTH-1:0]            pc_next_o
);

    logic [WIDTH-1:0] src_arr [NSRC];
    logic [SEL_W-1:0] sel_clamped;

    assign src_arr[0] = epc_i;

    genvar gi;
    generate
        for (gi = 1; gi < NSRC; gi++) begin : g_unpack
            assign src_arr[gi] = src_flat_i[gi*WIDTH-1 -: WIDTH];
        end
    endgenerate

    // Compare in integer width so NSRC = 2**SEL_W does not wrap to zero.
    assign sel_clamped = (int'(sel_i) >= NSRC) ? SEL_W'(NSRC - 1) : sel_i;
    assign pc_next_o   = src_arr[sel_clamped];

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC source selection, PC and EPC registers and a
// two-state trap sequencer (RUN/TRAP) with cause capture.
// Optional feature: define PC_ALIGN_CHECK_EN to trap (cause 2) on any
// load whose target address is not word aligned.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int          NSRC     = 5,
    parameter int          SEL_W    = $clog2(NSRC),
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter logic [31:0] EXC_VEC  = DEF_EXC_VEC
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [(NSRC-1)*WIDTH-1:0]   src_flat,
    input  logic [SEL_W-1:0]            pc_sel,
    input  logic                        pc_write,
    input  logic                        pc_write_cond,
    input  logic                        cond,
    input  logic                        exc_req,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            epc,
    output logic [WIDTH-1:0]            pc_next,
    output logic [1:0]                  cause,
    output logic                        exc_ack,
    output logic                        sel_err
);

    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    cause_e           cause_q, cause_d;
    logic             sel_err_q, sel_err_d;

    logic load;
    logic sel_oor;
    logic misalign;

    pc_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_src_mux (
        .epc_i      (epc_q),
        .src_flat_i (src_flat),
        .sel_i      (pc_sel),
        .pc_next_o  (pc_next)
    );

    assign load    = pc_write | (pc_write_cond & cond);
    assign sel_oor = (int'(pc_sel) >= NSRC);

`ifdef PC_ALIGN_CHECK_EN
    assign misalign = (pc_next[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Next-state logic: trap entry has priority over any load in RUN;
    // TRAP always lasts a single cycle and ignores all requests.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        cause_d   = cause_q;
        sel_err_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_PC;
                    cause_d = CAUSE_EXT;
                    state_d = ST_TRAP;
                end else if (load && misalign) begin
                    epc_d   = pc_q;
                    pc_d    = EXC_PC;
                    cause_d = CAUSE_MISALIGN;
                    state_d = ST_TRAP;
                end else if (load) begin
                    pc_d      = pc_next;
                    sel_err_d = sel_oor;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            cause_q   <= CAUSE_NONE;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign pc      = pc_q;
    assign epc     = epc_q;
    assign cause   = cause_q;
    assign exc_ack = (state_q == ST_TRAP);
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (WIDTH 32, NSRC 5): directed walk through
// the main scenarios followed by randomized traffic, all compared against a
// transaction-level model of the PC/EPC/trap behaviour.
module tb_pc_unit;

    localparam int          WIDTH = 32;
    localparam int          NSRC  = 5;
    localparam int          SEL_W = 3;
    localparam logic [31:0] RST_PC = 32'h0;
    localparam logic [31:0] EXCV   = 32'h0000_00FC;

    logic                      clk = 1'b0;
    logic                      reset_n = 1'b0;
    logic [(NSRC-1)*WIDTH-1:0] src_flat = '0;
    logic [SEL_W-1:0]          pc_sel = '0;
    logic                      pc_write = 1'b0;
    logic                      pc_write_cond = 1'b0;
    logic                      cond = 1'b0;
    logic                      exc_req = 1'b0;
    logic [WIDTH-1:0]          pc, epc, pc_next;
    logic [1:0]                cause;
    logic                      exc_ack, sel_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] srcs [1:NSRC-1];
    logic [31:0] m_pc, m_epc;
    logic [1:0]  m_cause;
    logic        m_in_trap, m_sel_err;

    pc_unit #(
        .WIDTH    (WIDTH),
        .NSRC     (NSRC),
        .SEL_W    (SEL_W),
        .RESET_PC (RST_PC),
        .EXC_VEC  (EXCV)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .src_flat      (src_flat),
        .pc_sel        (pc_sel),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond          (cond),
        .exc_req       (exc_req),
        .pc            (pc),
        .epc           (epc),
        .pc_next       (pc_next),
        .cause         (cause),
        .exc_ack       (exc_ack),
        .sel_err       (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [SEL_W-1:0] sel);
        if (sel == 0)               return m_epc;
        else if (int'(sel) >= NSRC) return srcs[NSRC-1];
        else                        return srcs[int'(sel)];
    endfunction

    task automatic model_reset();
        m_pc = RST_PC; m_epc = '0; m_cause = 2'd0; m_in_trap = 1'b0; m_sel_err = 1'b0;
    endtask

    task automatic set_srcs();
        for (int k = 1; k < NSRC; k++) src_flat[k*WIDTH-1 -: WIDTH] = srcs[k];
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc"},      pc,      m_pc);
        check({tag, ".epc"},     epc,     m_epc);
        check({tag, ".cause"},   {30'd0, cause},   {30'd0, m_cause});
        check({tag, ".exc_ack"}, {31'd0, exc_ack}, {31'd0, m_in_trap});
        check({tag, ".sel_err"}, {31'd0, sel_err}, {31'd0, m_sel_err});
    endtask

    // One cycle: apply inputs (called just after a falling edge), check the
    // combinational select, advance the model over the rising edge, check.
    task automatic step(input string tag, input logic [SEL_W-1:0] sel,
                        input logic w, input logic wc, input logic c, input logic e);
        logic [31:0] nxt;
        logic        ld;
        pc_sel = sel; pc_write = w; pc_write_cond = wc; cond = c; exc_req = e;
        set_srcs();
        #1;
        nxt = model_next(sel);
        check({tag, ".pc_next"}, pc_next, nxt);
        ld = w | (wc & c);
        @(posedge clk);
        if (m_in_trap) begin
            m_in_trap = 1'b0; m_sel_err = 1'b0;
        end else if (e) begin
            m_epc = m_pc; m_pc = EXCV; m_cause = 2'd1; m_in_trap = 1'b1; m_sel_err = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        end else if (ld && nxt[1:0] != 2'b00) begin
            m_epc = m_pc; m_pc = EXCV; m_cause = 2'd2; m_in_trap = 1'b1; m_sel_err = 1'b0;
`endif
        end else if (ld) begin
            m_pc = nxt; m_sel_err = (int'(sel) >= NSRC);
        end else begin
            m_sel_err = 1'b0;
        end
        #1;
        check_regs(tag);
        $display("step %-8s sel=%0d w=%0b wc=%0b c=%0b e=%0b -> pc=%08h epc=%08h cause=%0d ack=%0b serr=%0b",
                 tag, sel, w, wc, c, e, pc, epc, cause, exc_ack, sel_err);
        @(negedge clk);
    endtask

    initial begin
        srcs[1] = 32'h0; srcs[2] = 32'h40; srcs[3] = 32'h80; srcs[4] = 32'hC0;
        set_srcs();
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("reset");
        reset_n = 1'b1;

        // Directed scenarios
        step("ld40", 3'd2, 1, 0, 0, 0);
        check("dir.pc40", pc, 32'h40);
        step("cond0", 3'd3, 0, 1, 0, 0);
        check("dir.hold", pc, 32'h40);
        step("cond1", 3'd3, 0, 1, 1, 0);
        check("dir.pc80", pc, 32'h80);
        step("exc", 3'd4, 1, 0, 0, 1);
        check("dir.excpc", pc, EXCV);
        check("dir.excepc", epc, 32'h80);
        step("trap", 3'd0, 1, 0, 0, 1);
        check("dir.ack", {31'd0, exc_ack}, 32'd0);
        step("eret", 3'd0, 1, 0, 0, 0);
        check("dir.eret", pc, 32'h80);
        step("oor", 3'd7, 1, 0, 0, 0);
        check("dir.oorpc", pc, 32'hC0);
        check("dir.oorerr", {31'd0, sel_err}, 32'd1);
        step("idle", 3'd0, 0, 0, 0, 0);
        step("ld40b", 3'd2, 1, 0, 0, 0);
        srcs[1] = 32'h42;
        step("unalign", 3'd1, 1, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
        check("dir.mapc", pc, EXCV);
        check("dir.macause", {30'd0, cause}, 32'd2);
`else
        check("dir.mapc", pc, 32'h42);
`endif
        step("idle2", 3'd0, 0, 0, 0, 0);
        step("exc2", 3'd0, 0, 0, 0, 1);

        // Reset asserted during TRAP
        reset_n = 1'b0;
        #1;
        model_reset();
        check_regs("rsttrap");
        @(negedge clk);
        reset_n = 1'b1;
        step("postrst", 3'd3, 1, 0, 0, 0);
        check("dir.postrst", pc, 32'h80);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 1; k < NSRC; k++) begin
                srcs[k] = $urandom();
                if ($urandom_range(0, 1) == 0) srcs[k][1:0] = 2'b00;
            end
            step("rand", SEL_W'($urandom_range(0, 7)),
                 ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
